mem_access_ctrl: RTL

- MEM-stage SRAM access controller of the 16-bit pipelined CPU, between the EX/MEM register and the MEM/WB register.
- Converts a single-cycle load/store request into a multi-cycle external SRAM transaction with chip-enable, output-enable and write-enable strobes.
- Stalls the upstream pipeline while the transaction runs.
- Presents the registered load result on memdata_out for the MEM/WB register.

---
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the MEM-stage access controller, the pipeline registers and the external SRAM.
// The controller uses the slave modport; the pipeline/SRAM side uses the master modport.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 18
);
   logic              memread_in;
   logic              memwrite_in;
   logic [15:0]       addr_in;
   logic [15:0]       wdata_in;
   logic [15:0]       ram_din;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_dout;
   logic              ram_data_oe;
   logic              ram_ce_n;
   logic              ram_oe_n;
   logic              ram_we_n;
   logic              stall;
   logic [15:0]       memdata_out;
   logic              done;

   modport slave (
      input  memread_in, memwrite_in, addr_in, wdata_in, ram_din,
      output ram_addr, ram_dout, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n,
      output stall, memdata_out, done
   );

   modport master (
      output memread_in, memwrite_in, addr_in, wdata_in, ram_din,
      input  ram_addr, ram_dout, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n,
      input  stall, memdata_out, done
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage SRAM access controller: turns a one-cycle load/store request into a
// SETUP / STROBE / FINISH SRAM cycle, stalling the pipeline until the data is in.
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 18
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus
);
   localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
   localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, FINISH} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      addr_q, addr_d;
   logic [15:0]      dout_q, dout_d;
   logic [15:0]      rdata_q, rdata_d;
   logic             is_wr_q, is_wr_d;
   logic             ce_n_q, ce_n_d;
   logic             oe_n_q, oe_n_d;
   logic             we_n_q, we_n_d;
   logic             data_oe_q, data_oe_d;
   logic             done_q, done_d;
   logic             req;
   logic             stall_c;

   assign req = bus.memread_in | bus.memwrite_in;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;
      is_wr_d = is_wr_q;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            stall_c = req;
            if (req) begin
               addr_d  = bus.addr_in;
               // Store wins when both request lines are raised together.
               is_wr_d = bus.memwrite_in;
               if (bus.memwrite_in) dout_d = bus.wdata_in;
               state_d = SETUP;
            end
         end
         SETUP: begin
            stall_c = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = STROBE;
         end
         STROBE: begin
            stall_c = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = FINISH;
               if (!is_wr_q) rdata_d = bus.ram_din;
            end
         end
         FINISH: begin
            // The request still visible here belongs to the departing instruction.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state and registered so the pins never glitch.
      ce_n_d    = (state_d == IDLE);
      oe_n_d    = !((state_d == STROBE) && !is_wr_d);
      we_n_d    = !((state_d == STROBE) && is_wr_d);
      data_oe_d = is_wr_d && (state_d != IDLE);
      done_d    = (state_d == FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         dout_q    <= '0;
         rdata_q   <= '0;
         is_wr_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         rdata_q   <= rdata_d;
         is_wr_q   <= is_wr_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
      end
   end

   generate
      if (ADDR_W > 16) begin : g_addr_zext
         assign bus.ram_addr = {{(ADDR_W-16){1'b0}}, addr_q};
      end else begin : g_addr_trunc
         assign bus.ram_addr = addr_q[ADDR_W-1:0];
      end
   endgenerate

   assign bus.ram_dout    = dout_q;
   assign bus.ram_data_oe = data_oe_q;
   assign bus.ram_ce_n    = ce_n_q;
   assign bus.ram_oe_n    = oe_n_q;
   assign bus.ram_we_n    = we_n_q;
   assign bus.stall       = stall_c;
   assign bus.memdata_out = rdata_q;
   assign bus.done        = done_q;
endmodule
